// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (IF) and load/store (LS).
// One access in flight at a time; read data returns to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 48,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_adr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] memdata,
  output logic              busy
);

  localparam int         CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_ls_q, owner_ls_d;
  logic               rd_q, rd_d;
  logic               last_ls_q, last_ls_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pick_ls;

  logic               memread_d, memwrite_d;
  logic [ADDR_W-1:0]  adr_d;
  logic [DATA_W-1:0]  writedata_d;
  logic               if_gnt_d, ls_gnt_d;
  logic               if_rvalid_d, ls_rvalid_d;
  logic [DATA_W-1:0]  if_rdata_d, ls_rdata_d;
  logic               busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      rd_q       <= 1'b0;
      last_ls_q  <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      rd_q       <= rd_d;
      last_ls_q  <= last_ls_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    rd_d        = rd_q;
    last_ls_d   = last_ls_q;
    cnt_d       = cnt_q;
    pick_ls     = 1'b0;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    adr_d       = adr;
    writedata_d = writedata;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;

    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          // On a tie the side that did not win last time goes first.
          pick_ls     = ls_req && (!if_req || !last_ls_q);
          owner_ls_d  = pick_ls;
          last_ls_d   = pick_ls;
          rd_d        = pick_ls ? !ls_we : 1'b1;
          memread_d   = pick_ls ? !ls_we : 1'b1;
          memwrite_d  = pick_ls && ls_we;
          adr_d       = pick_ls ? ls_adr : if_adr;
          writedata_d = (pick_ls && ls_we) ? ls_wdata : '0;
          if_gnt_d    = !pick_ls;
          ls_gnt_d    = pick_ls;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_q) begin
          cnt_d   = LAT;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // memdata is valid in the cycle the counter would step to zero.
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (owner_ls_q) begin
            ls_rdata_d  = memdata;
            ls_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = memdata;
            if_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memread   <= 1'b0;
      memwrite  <= 1'b0;
      adr       <= '0;
      writedata <= '0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      memread   <= memread_d;
      memwrite  <= memwrite_d;
      adr       <= adr_d;
      writedata <= writedata_d;
      if_gnt    <= if_gnt_d;
      ls_gnt    <= ls_gnt_d;
      if_rvalid <= if_rvalid_d;
      ls_rvalid <= ls_rvalid_d;
      if_rdata  <= if_rdata_d;
      ls_rdata  <= ls_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2; expected values are hand-derived cycle by cycle.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_adr, ls_adr;
  logic [DW-1:0] ls_wdata, memdata;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata, writedata;
  logic          memread, memwrite, busy;
  logic [AW-1:0] adr;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_adr(ls_adr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .memread(memread), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    tests++;
    if ({memread, memwrite, if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000000", {memread, memwrite, if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy});
    end
    tests++;
    if (adr !== '0 || writedata !== '0) begin
      fails++; $display("FAIL reset_bus: adr=%h wd=%h want 0", adr, writedata);
    end
    tests++;
    if (if_rdata !== '0 || ls_rdata !== '0) begin
      fails++; $display("FAIL reset_rdata: if=%h ls=%h want 0", if_rdata, ls_rdata);
    end
    reset = 1'b1;
    repeat (2) step();
    tests++;
    if ({memread, memwrite, busy} !== 3'b0) begin
      fails++; $display("FAIL reset_release: rd/wr/busy=%b want 000", {memread, memwrite, busy});
    end
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_adr = 12'h800;              // cycle C
    step();                                        // C+1
    tests++;
    if ({memread, memwrite, if_gnt, ls_gnt, busy} !== 5'b10101 || adr !== 12'h800 || writedata !== '0) begin
      fails++; $display("FAIL if_issue: rd/wr/ig/lg/busy=%b adr=%h wd=%h want 10101 800 0",
                        {memread, memwrite, if_gnt, ls_gnt, busy}, adr, writedata);
    end
    if_req = 1'b0;
    step();                                        // C+2
    memdata = 48'h0BAD_0BAD_0BAD;
    tests++;
    if ({memread, if_gnt, busy} !== 3'b001 || adr !== 12'h800) begin
      fails++; $display("FAIL if_wait: rd/ig/busy=%b adr=%h want 001 800", {memread, if_gnt, busy}, adr);
    end
    step();                                        // C+3
    memdata = 48'h1234_5678_9ABC;
    step();                                        // C+4
    memdata = 48'h0BAD_0BAD_0BAD;
    tests++;
    if (if_rvalid !== 1'b1 || if_rdata !== 48'h1234_5678_9ABC || ls_rvalid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL if_rvalid: iv=%b rdata=%h lv=%b busy=%b want 1 123456789abc 0 0",
                        if_rvalid, if_rdata, ls_rvalid, busy);
    end
    step();                                        // C+5
    tests++;
    if (if_rvalid !== 1'b0 || if_rdata !== 48'h1234_5678_9ABC) begin
      fails++; $display("FAIL if_hold: iv=%b rdata=%h want 0 123456789abc", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_tie();
    do_reset();
    memdata = 48'h0000_0000_AAAA;
    if_req = 1'b1; if_adr = 12'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_adr = 12'h010;  // cycle C
    step();                                          // C+1
    tests++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || adr !== 12'h100) begin
      fails++; $display("FAIL tie_first: ig=%b lg=%b adr=%h want 1 0 100", if_gnt, ls_gnt, adr);
    end
    if_req = 1'b0;
    repeat (3) step();                               // C+4
    tests++;
    if (if_rvalid !== 1'b1 || if_rdata !== 48'h0000_0000_AAAA || ls_gnt !== 1'b0) begin
      fails++; $display("FAIL tie_ifdata: iv=%b rdata=%h lg=%b want 1 aaaa 0", if_rvalid, if_rdata, ls_gnt);
    end
    memdata = 48'h0000_0000_5555;
    step();                                          // C+5
    tests++;
    if (ls_gnt !== 1'b1 || memread !== 1'b1 || adr !== 12'h010) begin
      fails++; $display("FAIL tie_second: lg=%b rd=%b adr=%h want 1 1 010", ls_gnt, memread, adr);
    end
    ls_req = 1'b0;
    repeat (3) step();                               // C+8
    tests++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 48'h0000_0000_5555 || if_rvalid !== 1'b0) begin
      fails++; $display("FAIL tie_lsdata: lv=%b rdata=%h iv=%b want 1 5555 0", ls_rvalid, ls_rdata, if_rvalid);
    end
  endtask

  task automatic test_store();
    int wr_cycles = 0;
    int ls_rv = 0;
    ls_req = 1'b1; ls_we = 1'b1; ls_adr = 12'h020; ls_wdata = 48'hFFFF_0000_0001;  // cycle C
    step();                                          // C+1
    if (memwrite) wr_cycles++;
    if (ls_rvalid) ls_rv++;
    tests++;
    if ({memwrite, memread, ls_gnt} !== 3'b101 || adr !== 12'h020 || writedata !== 48'hFFFF_0000_0001) begin
      fails++; $display("FAIL store_issue: wr/rd/lg=%b adr=%h wd=%h want 101 020 ffff00000001",
                        {memwrite, memread, ls_gnt}, adr, writedata);
    end
    ls_req = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; if_adr = 12'h345;
    step();                                          // C+2
    if (memwrite) wr_cycles++;
    if (ls_rvalid) ls_rv++;
    tests++;
    if (if_gnt !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL store_idle: ig=%b busy=%b want 0 0", if_gnt, busy);
    end
    step();                                          // C+3
    if (memwrite) wr_cycles++;
    if (ls_rvalid) ls_rv++;
    tests++;
    if (if_gnt !== 1'b1 || memread !== 1'b1 || adr !== 12'h345) begin
      fails++; $display("FAIL store_next: ig=%b rd=%b adr=%h want 1 1 345", if_gnt, memread, adr);
    end
    if_req = 1'b0;
    repeat (3) begin
      step();                                        // C+4..C+6
      if (memwrite) wr_cycles++;
      if (ls_rvalid) ls_rv++;
    end
    tests++;
    if (if_rvalid !== 1'b1) begin
      fails++; $display("FAIL store_fetch_rvalid: iv=%b want 1", if_rvalid);
    end
    tests++;
    if (wr_cycles != 1 || ls_rv != 0) begin
      fails++; $display("FAIL store_pulses: memwrite cycles=%0d ls_rvalid=%0d want 1 0", wr_cycles, ls_rv);
    end
  endtask

  task automatic test_back_to_back();
    int got[6];
    int n = 0;
    int both = 0;
    int cyc = 0;
    do_reset();
    if_req = 1'b1; if_adr = 12'h0F0;
    ls_req = 1'b1; ls_we = 1'b1; ls_adr = 12'h0F8; ls_wdata = 48'h0000_1111_2222;
    while (n < 6 && cyc < 60) begin
      step();
      cyc++;
      if (memread && memwrite) both++;
      if (if_gnt && ls_gnt) both++;
      if (if_gnt) begin got[n] = 0; n++; end
      else if (ls_gnt) begin got[n] = 1; n++; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (6) begin
      step();
      if (memread && memwrite) both++;
    end
    tests++;
    if (n != 6) begin
      fails++; $display("FAIL b2b_count: grants=%0d want 6 within budget", n);
    end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got[i] != (i % 2)) begin
        fails++; $display("FAIL b2b_order[%0d]: got %0d want %0d (0=IF 1=LS)", i, got[i], i % 2);
      end
    end
    tests++;
    if (both != 0) begin
      fails++; $display("FAIL b2b_exclusive: overlap cycles=%0d want 0", both);
    end
  endtask

  task automatic test_reset_mid();
    int rv = 0;
    memdata = 48'h0000_0000_0777;
    if_req = 1'b1; if_adr = 12'h0AA;               // cycle C
    step();                                         // C+1 issue
    if_req = 1'b0;
    step();                                         // C+2 in WAIT
    tests++;
    if (busy !== 1'b1 || if_rdata === '0) begin
      fails++; $display("FAIL mid_pre: busy=%b rdata=%h want 1 nonzero", busy, if_rdata);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || if_rdata !== '0 || if_rvalid !== 1'b0 || adr !== '0) begin
      fails++; $display("FAIL mid_reset: busy=%b rdata=%h iv=%b adr=%h want 0 0 0 0", busy, if_rdata, if_rvalid, adr);
    end
    repeat (2) begin
      step();
      if (if_rvalid) rv++;
    end
    reset = 1'b1;
    repeat (4) begin
      step();
      if (if_rvalid) rv++;
    end
    tests++;
    if (rv != 0 || if_rdata !== '0) begin
      fails++; $display("FAIL mid_dropped: rvalid pulses=%0d rdata=%h want 0 0", rv, if_rdata);
    end
    memdata = 48'h0000_0000_0BBB;
    if_req = 1'b1; if_adr = 12'h0BB;               // cycle C'
    step();                                         // C'+1
    tests++;
    if (if_gnt !== 1'b1 || adr !== 12'h0BB) begin
      fails++; $display("FAIL mid_refetch_gnt: ig=%b adr=%h want 1 0bb", if_gnt, adr);
    end
    if_req = 1'b0;
    repeat (3) step();                              // C'+4
    tests++;
    if (if_rvalid !== 1'b1 || if_rdata !== 48'h0000_0000_0BBB) begin
      fails++; $display("FAIL mid_refetch_data: iv=%b rdata=%h want 1 bbb", if_rvalid, if_rdata);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_adr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_adr = '0; ls_wdata = '0;
    memdata = '0;
    test_reset();
    test_if_read();
    test_tie();
    test_store();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
